// File: rtl/mig_resp_pkg.sv
// Shared encodings for the MIG application-interface responder model.
package mig_resp_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam int unsigned BURST_BEATS = 2;

  localparam int unsigned ERR_ILLEGAL_CMD = 0;
  localparam int unsigned ERR_PUSH_FULL   = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_WAIT,
    ST_WR_B0,
    ST_WR_B1,
    ST_RD_B0,
    ST_RD_B1
  } resp_state_t;

endpackage

// File: rtl/mig_resp_sync_fifo.sv
// Synchronous FIFO with occupancy count, registered almost-full and a
// push-while-full pulse; pushes are ignored while i_enable is low.
module mig_resp_sync_fifo #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_MARGIN = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_hold_afull,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_afull,
  output logic             o_overflow
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_afull;

  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [CW-1:0]    w_count_nxt;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_push_ok = i_enable & i_push & ~w_full;
  assign w_pop_ok  = i_pop & (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok)
      w_count_nxt = r_count + CW'(1);
    else if (!w_push_ok && w_pop_ok)
      w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_afull <= 1'b1;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_afull <= i_hold_afull || (w_count_nxt >= CW'(DEPTH - AFULL_MARGIN));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data;
  end

  assign o_data     = r_mem[r_rptr];
  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);
  assign o_afull    = r_afull;
  assign o_overflow = i_enable & i_push & w_full;

endmodule

// File: rtl/mig_app_responder.sv
// Behavioural MIG DDR2 user-interface responder: AF/WDF buffering, in-order
// execution against a line array, fixed-latency read return.
// Optional: define MIG_RESP_RAND_STALL_EN for LFSR-driven dispatch stalls.
module mig_app_responder
  import mig_resp_pkg::*;
#(
  parameter int unsigned APPDATA_WIDTH    = 128,
  parameter int unsigned INPUT_ADDR_WIDTH = 31,
  parameter int unsigned AF_DEPTH         = 8,
  parameter int unsigned WDF_DEPTH        = 16,
  parameter int unsigned AFULL_MARGIN     = 2,
  parameter int unsigned LINE_BITS        = 8,
  parameter int unsigned RD_LATENCY       = 6,
  parameter int unsigned INIT_CYCLES      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        phy_init_done,
  input  logic                        app_af_wren,
  input  logic [INPUT_ADDR_WIDTH-1:0] app_af_addr,
  input  logic [2:0]                  app_af_cmd,
  output logic                        app_af_afull,
  input  logic                        app_wdf_wren,
  input  logic [APPDATA_WIDTH-1:0]    app_wdf_data,
  input  logic [APPDATA_WIDTH/8-1:0]  app_wdf_mask_data,
  output logic                        app_wdf_afull,
  output logic                        rd_data_valid,
  output logic [APPDATA_WIDTH-1:0]    rd_data_fifo_out,
  output logic [1:0]                  err_sticky
);

  localparam int unsigned MASK_W    = APPDATA_WIDTH / 8;
  localparam int unsigned AF_W      = 3 + INPUT_ADDR_WIDTH;
  localparam int unsigned WDF_W     = MASK_W + APPDATA_WIDTH;
  localparam int unsigned NUM_BEATS = (1 << LINE_BITS) * BURST_BEATS;
  localparam int unsigned IDX_W     = LINE_BITS + 1;
  localparam int unsigned INIT_W    = $clog2(INIT_CYCLES + 1);
  localparam int unsigned AF_CW     = $clog2(AF_DEPTH + 1);
  localparam int unsigned WDF_CW    = $clog2(WDF_DEPTH + 1);

  logic [INIT_W-1:0] r_init_cnt;
  logic              r_init_done;
  logic              w_init_done_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else if (r_init_cnt != INIT_W'(INIT_CYCLES)) begin
      r_init_cnt <= r_init_cnt + INIT_W'(1);
    end else begin
      r_init_done <= 1'b1;
    end
  end

  // Lets both afull flags drop on the same edge that raises phy_init_done.
  assign w_init_done_nxt = r_init_done | (r_init_cnt == INIT_W'(INIT_CYCLES));

  logic [AF_W-1:0]   w_af_dout;
  logic [AF_CW-1:0]  w_af_count;
  logic              w_af_empty;
  logic              w_af_pop;
  logic              w_af_ovf;
  logic [WDF_W-1:0]  w_wdf_dout;
  logic [WDF_CW-1:0] w_wdf_count;
  logic              w_wdf_empty;
  logic              w_wdf_pop;
  logic              w_wdf_ovf;

  mig_resp_sync_fifo #(
    .WIDTH        (AF_W),
    .DEPTH        (AF_DEPTH),
    .AFULL_MARGIN (AFULL_MARGIN)
  ) u_af (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (r_init_done),
    .i_hold_afull (~w_init_done_nxt),
    .i_push       (app_af_wren),
    .i_data       ({app_af_cmd, app_af_addr}),
    .i_pop        (w_af_pop),
    .o_data       (w_af_dout),
    .o_count      (w_af_count),
    .o_empty      (w_af_empty),
    .o_afull      (app_af_afull),
    .o_overflow   (w_af_ovf)
  );

  mig_resp_sync_fifo #(
    .WIDTH        (WDF_W),
    .DEPTH        (WDF_DEPTH),
    .AFULL_MARGIN (AFULL_MARGIN)
  ) u_wdf (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (r_init_done),
    .i_hold_afull (~w_init_done_nxt),
    .i_push       (app_wdf_wren),
    .i_data       ({app_wdf_mask_data, app_wdf_data}),
    .i_pop        (w_wdf_pop),
    .o_data       (w_wdf_dout),
    .o_count      (w_wdf_count),
    .o_empty      (w_wdf_empty),
    .o_afull      (app_wdf_afull),
    .o_overflow   (w_wdf_ovf)
  );

  logic [2:0]               w_af_cmd;
  logic [LINE_BITS-1:0]     w_af_line;
  logic [MASK_W-1:0]        w_wdf_mask;
  logic [APPDATA_WIDTH-1:0] w_wdf_data;
  logic                     w_unused;

  assign w_af_cmd   = w_af_dout[AF_W-1 -: 3];
  assign w_af_line  = w_af_dout[LINE_BITS+1:2];
  assign w_wdf_mask = w_wdf_dout[WDF_W-1 -: MASK_W];
  assign w_wdf_data = w_wdf_dout[APPDATA_WIDTH-1:0];
  assign w_unused   = ^{w_af_count, w_wdf_empty,
                        w_af_dout[INPUT_ADDR_WIDTH-1:LINE_BITS+2], w_af_dout[1:0]};

  logic w_stall;

`ifdef MIG_RESP_RAND_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= 16'hACE1;
    else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  resp_state_t          r_state;
  logic [LINE_BITS-1:0] r_line;
  logic [1:0]           r_err;
  logic                 w_dispatch_slot;
  logic                 w_wdf_avail;
  logic                 w_beat;
  logic [IDX_W-1:0]     w_beat_idx;

  // Last beat of a burst also dispatches, so back-to-back reads stream gaplessly.
  assign w_dispatch_slot = (r_state == ST_IDLE) || (r_state == ST_WR_B1) || (r_state == ST_RD_B1);
  assign w_af_pop        = w_dispatch_slot & ~w_af_empty & ~w_stall;
  assign w_wdf_pop       = (r_state == ST_WR_B0) || (r_state == ST_WR_B1);
  assign w_wdf_avail     = (w_wdf_count - WDF_CW'(w_wdf_pop)) >= WDF_CW'(BURST_BEATS);
  assign w_beat          = (r_state == ST_WR_B1) || (r_state == ST_RD_B1);
  assign w_beat_idx      = {r_line, w_beat};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_line  <= '0;
      r_err   <= '0;
    end else begin
      if (w_af_ovf || w_wdf_ovf) r_err[ERR_PUSH_FULL] <= 1'b1;
      case (r_state)
        ST_IDLE, ST_WR_B1, ST_RD_B1: begin
          r_state <= ST_IDLE;
          if (w_af_pop) begin
            r_line <= w_af_line;
            case (w_af_cmd)
              CMD_WRITE: r_state <= w_wdf_avail ? ST_WR_B0 : ST_WR_WAIT;
              CMD_READ:  r_state <= ST_RD_B0;
              default:   r_err[ERR_ILLEGAL_CMD] <= 1'b1;
            endcase
          end
        end
        ST_WR_WAIT: if (w_wdf_avail) r_state <= ST_WR_B0;
        ST_WR_B0:   r_state <= ST_WR_B1;
        ST_RD_B0:   r_state <= ST_RD_B1;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  logic [APPDATA_WIDTH-1:0] r_store [NUM_BEATS];

  always_ff @(posedge clk) begin
    if (!rst && w_wdf_pop) begin
      for (int unsigned b = 0; b < MASK_W; b++) begin
        if (!w_wdf_mask[b]) r_store[w_beat_idx][b*8 +: 8] <= w_wdf_data[b*8 +: 8];
      end
    end
  end

  logic [RD_LATENCY-1:0]    r_pipe_vld;
  logic [APPDATA_WIDTH-1:0] r_pipe_data [RD_LATENCY];
  logic                     w_rd_push;

  assign w_rd_push = (r_state == ST_RD_B0) || (r_state == ST_RD_B1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_vld <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) r_pipe_data[i] <= '0;
    end else begin
      r_pipe_vld     <= {r_pipe_vld[RD_LATENCY-2:0], w_rd_push};
      r_pipe_data[0] <= r_store[w_beat_idx];
      for (int unsigned i = 1; i < RD_LATENCY; i++) r_pipe_data[i] <= r_pipe_data[i-1];
    end
  end

  assign phy_init_done    = r_init_done;
  assign rd_data_valid    = r_pipe_vld[RD_LATENCY-1];
  assign rd_data_fifo_out = r_pipe_data[RD_LATENCY-1];
  assign err_sticky       = r_err;

endmodule

// File: tb/tb_mig_app_responder.sv
// Self-checking bench for mig_app_responder: vector table plus scoreboard
// of expected read beats, and hand sequences for init, stall, error and reset.
module tb_mig_app_responder;

  localparam int unsigned DW      = 128;
  localparam int unsigned AWID    = 31;
  localparam int unsigned RD_LAT  = 6;
  localparam int unsigned INIT_C  = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            phy_init_done;
  logic            app_af_wren = 1'b0;
  logic [AWID-1:0] app_af_addr = '0;
  logic [2:0]      app_af_cmd = '0;
  logic            app_af_afull;
  logic            app_wdf_wren = 1'b0;
  logic [DW-1:0]   app_wdf_data = '0;
  logic [DW/8-1:0] app_wdf_mask_data = '0;
  logic            app_wdf_afull;
  logic            rd_data_valid;
  logic [DW-1:0]   rd_data_fifo_out;
  logic [1:0]      err_sticky;

  mig_app_responder #(
    .APPDATA_WIDTH    (DW),
    .INPUT_ADDR_WIDTH (AWID),
    .AF_DEPTH         (8),
    .WDF_DEPTH        (16),
    .AFULL_MARGIN     (2),
    .LINE_BITS        (8),
    .RD_LATENCY       (RD_LAT),
    .INIT_CYCLES      (INIT_C)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .phy_init_done     (phy_init_done),
    .app_af_wren       (app_af_wren),
    .app_af_addr       (app_af_addr),
    .app_af_cmd        (app_af_cmd),
    .app_af_afull      (app_af_afull),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_mask_data (app_wdf_mask_data),
    .app_wdf_afull     (app_wdf_afull),
    .rd_data_valid     (rd_data_valid),
    .rd_data_fifo_out  (rd_data_fifo_out),
    .err_sticky        (err_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: every valid beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rd_data_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected actual=%h required=no_beat", rd_data_fifo_out);
      end else begin
        check("rd_beat", rd_data_fifo_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic [DW/8-1:0] m);
    app_wdf_wren = 1'b1;
    app_wdf_data = d;
    app_wdf_mask_data = m;
    tick();
    app_wdf_wren = 1'b0;
  endtask

  task automatic push_cmd(input logic [2:0] c, input logic [AWID-1:0] a);
    app_af_wren = 1'b1;
    app_af_cmd = c;
    app_af_addr = a;
    tick();
    app_af_wren = 1'b0;
  endtask

  task automatic push_read(input logic [AWID-1:0] a, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    push_cmd(3'b001, a);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s pending_beats=%0d required=0", name, exp_q.size());
    end
  endtask

  task automatic wait_valid(input int limit, output int k);
    k = 0;
    while (!rd_data_valid && k < limit) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_init(output int k);
    k = 0;
    while (!phy_init_done && k < 100) begin
      tick();
      k++;
    end
  endtask

  typedef struct {
    logic            is_wr;
    logic [AWID-1:0] addr;
    logic [DW-1:0]   d0, d1;
    logic [DW/8-1:0] m0, m1;
    logic [DW-1:0]   e0, e1;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [AWID-1:0] a,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [DW/8-1:0] m0, input logic [DW/8-1:0] m1,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    vec_t v;
    v.is_wr = w; v.addr = a; v.d0 = d0; v.d1 = d1;
    v.m0 = m0; v.m1 = m1; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  localparam logic [DW-1:0] P11 = {16{8'h11}};
  localparam logic [DW-1:0] P22 = {16{8'h22}};
  localparam logic [DW-1:0] PAA = {16{8'hAA}};
  localparam logic [DW-1:0] P55 = {16{8'h55}};
  localparam logic [DW-1:0] P33 = {16{8'h33}};
  localparam logic [DW-1:0] P44 = {16{8'h44}};
  localparam logic [DW-1:0] P66 = {16{8'h66}};
  localparam logic [DW-1:0] P77 = {16{8'h77}};
  localparam logic [DW-1:0] M1FF = {{15{8'h11}}, 8'hFF};
  localparam logic [DW-1:0] MEE  = {8'hEE, {14{8'h11}}, 8'hFF};

  vec_t tbl [9];

  initial begin
    int k;
    int run;

    tbl[0] = mk(1'b1, 31'h40,  P11, P22, 16'h0000, 16'h0000, '0, '0);
    tbl[1] = mk(1'b0, 31'h40,  '0, '0, '0, '0, P11, P22);
    tbl[2] = mk(1'b1, 31'h40,  128'hFF, '0, 16'hFFFE, 16'hFFFF, '0, '0);
    tbl[3] = mk(1'b0, 31'h40,  '0, '0, '0, '0, M1FF, P22);
    tbl[4] = mk(1'b1, 31'h80,  PAA, P55, 16'h0000, 16'h0000, '0, '0);
    tbl[5] = mk(1'b1, 31'h43,  {8'hEE, 120'h0}, '0, 16'h7FFF, 16'hFFFF, '0, '0);
    tbl[6] = mk(1'b0, 31'h80,  '0, '0, '0, '0, PAA, P55);
    tbl[7] = mk(1'b0, 31'h40,  '0, '0, '0, '0, MEE, P22);
    tbl[8] = mk(1'b0, 31'h440, '0, '0, '0, '0, MEE, P22);

    // Reset values.
    tick(); tick(); tick();
    check("rst_phy_init_done", 128'(phy_init_done), 128'd0);
    check("rst_af_afull", 128'(app_af_afull), 128'd1);
    check("rst_wdf_afull", 128'(app_wdf_afull), 128'd1);
    check("rst_rd_valid", 128'(rd_data_valid), 128'd0);
    check("rst_rd_data", rd_data_fifo_out, 128'd0);
    check("rst_err", 128'(err_sticky), 128'd0);

    // Init: phy_init_done rises on edge INIT_CYCLES+1 after release.
    rst = 1'b0;
    wait_init(k);
    check("init_cycles", 128'(k), 128'(INIT_C + 1));
    check("init_af_afull", 128'(app_af_afull), 128'd0);
    check("init_wdf_afull", 128'(app_wdf_afull), 128'd0);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].is_wr) begin
        push_beat(tbl[i].d0, tbl[i].m0);
        push_beat(tbl[i].d1, tbl[i].m1);
        push_cmd(3'b000, tbl[i].addr);
      end else begin
        push_read(tbl[i].addr, tbl[i].e0, tbl[i].e1);
      end
    end
    drain("table_drain");
    tick(); tick();

    // Read latency from idle: command accepted, then one dispatch cycle, then RD_LATENCY.
    push_read(31'h80, PAA, P55);
    wait_valid(30, k);
    check("rd_latency", 128'(k), 128'(RD_LAT + 1));
    tick();
    check("rd_valid_beat1", 128'(rd_data_valid), 128'd1);
    tick();
    check("rd_valid_end", 128'(rd_data_valid), 128'd0);
    drain("latency_drain");

    // Write command without data parks the FSM; fill the address FIFO behind it.
    push_cmd(3'b000, 31'hC0);
    tick();
    push_read(31'hC0, P33, P44);
    for (int i = 1; i < 5; i++) push_read(31'h80, PAA, P55);
    check("af_afull_cnt5", 128'(app_af_afull), 128'd0);
    push_read(31'h80, PAA, P55);
    check("af_afull_cnt6", 128'(app_af_afull), 128'd1);
    push_read(31'h80, PAA, P55);
    push_read(31'h80, PAA, P55);
    check("err_full_before", 128'(err_sticky[1]), 128'd0);
    push_cmd(3'b001, 31'h80);
    check("err_full_after", 128'(err_sticky[1]), 128'd1);
    push_beat(P33, 16'h0000);
    push_beat(P44, 16'h0000);
    wait_valid(60, k);
    run = 0;
    while (rd_data_valid && run < 40) begin
      tick();
      run++;
    end
    check("b2b_valid_run", 128'(run), 128'd16);
    drain("stall_drain");

    // Illegal command is discarded; the following read proceeds normally.
    check("err_illegal_before", 128'(err_sticky[0]), 128'd0);
    push_cmd(3'b111, 31'h40);
    push_read(31'hC0, P33, P44);
    drain("illegal_drain");
    check("err_illegal_after", 128'(err_sticky[0]), 128'd1);

    // Reset mid-burst with more work queued behind it.
    push_read(31'h80, PAA, P55);
    push_read(31'h40, MEE, P22);
    push_beat({16{8'h99}}, 16'h0000);
    push_beat({16{8'h88}}, 16'h0000);
    wait_valid(40, k);
    check("pre_reset_valid", 128'(rd_data_valid), 128'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 128'(rd_data_valid), 128'd0);
    check("mid_rst_phy", 128'(phy_init_done), 128'd0);
    check("mid_rst_af_afull", 128'(app_af_afull), 128'd1);
    check("mid_rst_err", 128'(err_sticky), 128'd0);
    exp_q.delete();
    rst = 1'b0;
    wait_init(k);
    check("reinit_cycles", 128'(k), 128'(INIT_C + 1));
    push_beat(P66, 16'h0000);
    push_beat(P77, 16'h0000);
    push_cmd(3'b000, 31'hC0);
    push_read(31'hC0, P66, P77);
    drain("post_reset_drain");
    for (int i = 0; i < 20; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mig_app_responder.md
Name: mig_app_responder

Overview:
- Behavioural responder for the MIG DDR2 user-side application interface (address FIFO, write-data FIFO, read-data return).
- Sits where the MIG core sits and is driven by data_rd_wr.
- Buffers commands and write data, executes them in order against an internal line array, and returns read bursts after a fixed latency.
- Gives the cache/interface path a fast, deterministic memory model for simulation.

Parameters:
- APPDATA_WIDTH, 128, user data beat width.
- INPUT_ADDR_WIDTH, 31, app_af_addr width.
- AF_DEPTH, 8, address FIFO entries (power of 2).
- WDF_DEPTH, 16, write-data FIFO beats (power of 2).
- AFULL_MARGIN, 2, afull asserts at count >= DEPTH-AFULL_MARGIN.
- LINE_BITS, 8, log2 of storage lines (2 beats per line).
- RD_LATENCY, 6, cycles from read issue to first valid beat (>=2).
- INIT_CYCLES, 32, cycles after reset before phy_init_done.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- phy_init_done  out  1  model calibration complete
- app_af_wren  in  1  push command
- app_af_addr  in  INPUT_ADDR_WIDTH  column-granular address
- app_af_cmd  in  3  000 write, 001 read
- app_af_afull  out  1  address FIFO almost full
- app_wdf_wren  in  1  push write beat
- app_wdf_data  in  APPDATA_WIDTH  write beat
- app_wdf_mask_data  in  APPDATA_WIDTH/8  byte mask, 1 = byte not written
- app_wdf_afull  out  1  write-data FIFO almost full
- rd_data_valid  out  1  read beat valid
- rd_data_fifo_out  out  APPDATA_WIDTH  read beat
- err_sticky  out  2  [0] illegal cmd, [1] push while full

Behaviour:
- Reset values:
  - phy_init_done=0, app_af_afull=1, app_wdf_afull=1, rd_data_valid=0, rd_data_fifo_out=0, err_sticky=0.
  - FIFOs and read pipe emptied; FSM to IDLE.
  - Storage array is not reset.
- Init counter:
  - Counts INIT_CYCLES after rst deasserts; phy_init_done rises on the following cycle and stays high.
  - Before that, both afull outputs are held 1 and pushes are ignored without error.
- Address FIFO entry: {cmd, addr}.
  - app_af_afull = (count >= AF_DEPTH-AFULL_MARGIN), registered.
  - Push when full: dropped, err_sticky[1] set.
  - Simultaneous push+pop: count unchanged.
- Write-data FIFO: same rules for {mask, data}.
- Burst: every command is 2 beats (BURST_LEN 4 on 64-bit DQ).
  - Line index = app_af_addr[LINE_BITS+1:2]; low 2 bits ignored.
  - Higher bits alias.
- FSM states: IDLE, WR_WAIT, WR_B0, WR_B1, RD_B0, RD_B1.
  - IDLE: if AF non-empty, pop.
    - cmd 000 -> WR_B0 if WDF count>=2, else WR_WAIT.
    - cmd 001 -> RD_B0.
    - Other cmd -> discarded, err_sticky[0] set, stay IDLE.
  - WR_WAIT -> WR_B0 when WDF count>=2.
  - WR_B0/WR_B1: pop one WDF beat each and write beat 0/1 bytewise (mask bit 1 preserves byte) -> next / IDLE.
  - RD_B0/RD_B1: read beat 0/1 and push it into an RD_LATENCY-stage valid/data shift pipe -> next / IDLE.
- Read return:
  - rd_data_valid is high for exactly 2 consecutive cycles per read.
  - First beat appears RD_LATENCY cycles after RD_B0.
  - Back-to-back reads give continuous valid.
- Ordering:
  - Strict command order.
  - A read after a write to the same line returns the new data.
  - A write whose data arrives before its command is legal.
- Reset mid-operation:
  - In-flight command and queued data are discarded.
  - rd_data_valid drops the cycle after rst.

Optional Feature:
- MIG_RESP_RAND_STALL_EN defined:
  - A 16-bit LFSR (seed 16'hACE1 on reset) blocks IDLE pops on any cycle where lfsr[1:0]==2'b00.
  - Stresses the afull/backpressure paths.
- Undefined: no stalls; IDLE pops whenever AF is non-empty.

Decomposition:
- Package mig_resp_pkg:
  - command encodings CMD_WRITE=3'b000, CMD_READ=3'b001.
  - BURST_BEATS=2.
  - FSM state enum.
  - err_sticky bit indices.
- Sub-module mig_resp_sync_fifo: parameterised width/depth, count output, registered almost-full; instantiated for AF and WDF.

Test Plan:
- Reset, wait -> phy_init_done rises at cycle INIT_CYCLES+1; afull both 0.
- Push 2 beats (128'h1111..., 128'h2222..., mask 0) then write cmd to addr 0x40, then read 0x40 -> rd_data_valid high 2 cycles, data 1111... then 2222..., first beat RD_LATENCY cycles after RD_B0.
- Write 0x40 with beat0 mask 16'hFFFE, data 128'hFF -> re-read gives beat0 byte0=8'hFF, other bytes unchanged.
- Push 6 read cmds without popping (RAND_STALL on, or stall via write-cmd with no data) -> app_af_afull=1 at count 6; 9th push sets err_sticky[1].
- Cmd 3'b111 -> discarded, err_sticky[0]=1, next valid cmd executes normally.
- Assert rst for 1 cycle mid-read burst -> rd_data_valid 0 next cycle, FIFOs empty, phy_init_done 0.
